// File: rtl/frame_cmd_writer_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_pkg
// Shared definitions for frame_cmd_writer: the controller state encoding,
// the single-character opcodes and the frame-size helper.
// ----------------------------------------------------------------------------
package ctrl_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW_SEL,
    ROW_DATA,
    BRIGHT,
    RGB,
    FILL_COLOR,
    SWEEP
  } ctrl_state_t;

  localparam logic [7:0] OPC_ROW    = 8'h4C;  // 'L'
  localparam logic [7:0] OPC_BRIGHT = 8'h62;  // 'b'
  localparam logic [7:0] OPC_RGB    = 8'h72;  // 'r'
  localparam logic [7:0] OPC_CLEAR  = 8'h63;  // 'c'
  localparam logic [7:0] OPC_FILL   = 8'h66;  // 'f'

  function automatic int frame_bytes(input int cols, input int rows, input int bpp);
    return cols * rows * bpp;
  endfunction

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OPC_ROW) || (b == OPC_BRIGHT) || (b == OPC_RGB) ||
           (b == OPC_CLEAR) || (b == OPC_FILL);
  endfunction

endpackage

// File: rtl/frame_cmd_writer_if.sv
// ----------------------------------------------------------------------------
// frame_cmd_writer_if
// Byte-stream input and byte-wide frame-buffer RAM port of frame_cmd_writer.
//   data_rx / data_valid          : received byte and its one-cycle strobe
//   ram_address / ram_data_out    : RAM write address and data
//   ram_write_enable              : one-cycle write strobe
//   ram_clk_enable                : RAM clock enable (controller not idle)
// master = the controller, slave = byte source / RAM side.
// ----------------------------------------------------------------------------
interface frame_cmd_writer_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        data_rx;
  logic              data_valid;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_data_out;
  logic              ram_write_enable;
  logic              ram_clk_enable;

  modport master (
    input  data_rx, data_valid,
    output ram_address, ram_data_out, ram_write_enable, ram_clk_enable
  );

  modport slave (
    output data_rx, data_valid,
    input  ram_address, ram_data_out, ram_write_enable, ram_clk_enable
  );
endinterface

// File: rtl/frame_cmd_writer_sweeper.sv
// ----------------------------------------------------------------------------
// frame_sweeper
// Writes one colour over the whole frame buffer, one byte per clock.
//   clk_in, reset (sync, active-low)
//   start_i  : begin a sweep, colour taken from color_i (first byte in MSBs)
//   busy_o   : high for exactly FRAME_BYTES cycles, one write per cycle
//   last_o   : high during the final write cycle
//   addr_o / data_o : write address and colour byte for address mod BPP
// ----------------------------------------------------------------------------
module frame_sweeper #(
  parameter int FRAME_BYTES     = 4096,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int ADDR_W          = 12
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           start_i,
  input  logic [8*BYTES_PER_PIXEL-1:0]   color_i,
  output logic                           busy_o,
  output logic                           last_o,
  output logic [ADDR_W-1:0]              addr_o,
  output logic [7:0]                     data_o
);
  localparam int AW1   = ADDR_W + 1;
  localparam int SEL_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [AW1-1:0] LAST_ADDR = AW1'(FRAME_BYTES - 1);

  logic                         busy_q;
  logic [AW1-1:0]               addr_q;
  logic [SEL_W-1:0]             sel_q;
  logic [8*BYTES_PER_PIXEL-1:0] color_q;

  // Extra address bit keeps the end-of-frame compare free of wrap-around.
  assign last_o = busy_q && (addr_q == LAST_ADDR);
  assign busy_o = busy_q;
  assign addr_o = addr_q[ADDR_W-1:0];

  // sel_q tracks address mod BPP without a divider; byte 0 is the MSB byte.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (sel_q == SEL_W'(k)) data_o = color_q[8*(BYTES_PER_PIXEL-1-k) +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      color_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q  <= 1'b1;
      addr_q  <= '0;
      sel_q   <= '0;
      color_q <= color_i;
    end else if (busy_q) begin
      if (last_o) begin
        busy_q <= 1'b0;
      end else begin
        addr_q <= addr_q + 1'b1;
        sel_q  <= (sel_q == SEL_W'(BYTES_PER_PIXEL - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_cmd_writer.sv
// ----------------------------------------------------------------------------
// frame_cmd_writer
// Decodes single-character opcodes from a byte stream and writes the frame
// buffer: row loads ('L'), brightness ('b'), RGB enables ('r'), clear ('c')
// and fill ('f') sweeps, with inter-byte timeout and sticky overrun flag.
// Ports:
//   clk_in, reset (sync, active-low)
//   bus               : frame_cmd_writer_if.master (byte stream + RAM port)
//   rgb_enable        : colour-channel enables (reset 3'b111)
//   brightness_enable : brightness plane mask (reset all ones)
//   busy              : clear/fill sweep in progress
//   overrun           : sticky, byte received during a sweep
//   timeout           : one-cycle pulse when a command is abandoned
// Optional (macro CTRL_CMD_STATS_EN):
//   num_commands_processed : completed commands, wraps
//   num_invalid            : ignored opcodes, saturates at 255
// ----------------------------------------------------------------------------
module frame_cmd_writer
  import ctrl_cmd_pkg::*;
#(
  parameter int COLS             = 64,
  parameter int ROWS             = 32,
  parameter int BYTES_PER_PIXEL  = 2,
  parameter int BRIGHTNESS_BITS  = 6,
  parameter int RX_TIMEOUT_TICKS = 65535,
  parameter int ADDR_W           = $clog2(COLS*ROWS*BYTES_PER_PIXEL)
) (
  input  logic                       clk_in,
  input  logic                       reset,
  frame_cmd_writer_if.master         bus,
  output logic [2:0]                 rgb_enable,
  output logic [BRIGHTNESS_BITS-1:0] brightness_enable,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout
`ifdef CTRL_CMD_STATS_EN
  ,
  output logic [7:0]                 num_commands_processed,
  output logic [7:0]                 num_invalid
`endif
);
  localparam int FRAME_BYTES = frame_bytes(COLS, ROWS, BYTES_PER_PIXEL);
  localparam int ROW_BYTES   = COLS * BYTES_PER_PIXEL;
  localparam int AW1         = ADDR_W + 1;
  localparam int CW          = 8 * BYTES_PER_PIXEL;
  localparam int IDX_W       = $clog2(ROW_BYTES + 1);
  localparam int FIDX_W      = $clog2(BYTES_PER_PIXEL + 1);
  localparam int TO_W        = $clog2(RX_TIMEOUT_TICKS + 2);

  ctrl_state_t                state_q;
  logic [AW1-1:0]             base_q;
  logic [IDX_W-1:0]           idx_q;
  logic [FIDX_W-1:0]          fidx_q;
  logic [CW-1:0]              fill_q;
  logic [TO_W-1:0]            idle_q;
  logic                       row_we_q;
  logic [ADDR_W-1:0]          row_addr_q;
  logic [7:0]                 row_data_q;
  logic [2:0]                 rgb_q;
  logic [BRIGHTNESS_BITS-1:0] bright_q;
  logic                       overrun_q;
  logic                       timeout_q;

  logic                       sweep_start_d;
  logic [CW-1:0]              sweep_color_d;
  logic [CW-1:0]              fill_shift;
  logic [AW1-1:0]             row_base;
  logic [AW1-1:0]             row_full;
  logic                       to_hit;
  int                         row_c;

  logic                       sw_busy;
  logic                       sw_last;
  logic [ADDR_W-1:0]          sw_addr;
  logic [7:0]                 sw_data;

  assign fill_shift = (fill_q << 8) | CW'(bus.data_rx);
  assign row_full   = base_q + AW1'(idx_q);
  assign to_hit     = (RX_TIMEOUT_TICKS != 0) && (idle_q == TO_W'(RX_TIMEOUT_TICKS - 1));

  always_comb begin
    row_c    = (int'(bus.data_rx) >= ROWS) ? ROWS - 1 : int'(bus.data_rx);
    row_base = AW1'(row_c * ROW_BYTES);
  end

  // Sweep launch is decoded combinationally so the sweeper's first write
  // lines up with the controller entering SWEEP.
  always_comb begin
    sweep_start_d = 1'b0;
    sweep_color_d = '0;
    if (bus.data_valid) begin
      if (state_q == IDLE && bus.data_rx == OPC_CLEAR) begin
        sweep_start_d = 1'b1;
      end
      if (state_q == FILL_COLOR && fidx_q == FIDX_W'(BYTES_PER_PIXEL - 1)) begin
        sweep_start_d = 1'b1;
        sweep_color_d = fill_shift;
      end
    end
  end

  frame_sweeper #(
    .FRAME_BYTES    (FRAME_BYTES),
    .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
    .ADDR_W         (ADDR_W)
  ) u_sweeper (
    .clk_in (clk_in),
    .reset  (reset),
    .start_i(sweep_start_d),
    .color_i(sweep_color_d),
    .busy_o (sw_busy),
    .last_o (sw_last),
    .addr_o (sw_addr),
    .data_o (sw_data)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      fidx_q     <= '0;
      fill_q     <= '0;
      idle_q     <= '0;
      row_we_q   <= 1'b0;
      row_addr_q <= '0;
      row_data_q <= '0;
      rgb_q      <= 3'b111;
      bright_q   <= '1;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      row_we_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (bus.data_valid) begin
            case (bus.data_rx)
              OPC_ROW:    state_q <= ROW_SEL;
              OPC_BRIGHT: state_q <= BRIGHT;
              OPC_RGB:    state_q <= RGB;
              OPC_CLEAR:  state_q <= SWEEP;
              OPC_FILL: begin
                state_q <= FILL_COLOR;
                fidx_q  <= '0;
              end
              default: ;
            endcase
          end
        end
        SWEEP: begin
          // Bytes arriving mid-sweep are dropped.
          if (bus.data_valid) overrun_q <= 1'b1;
          if (sw_last) state_q <= IDLE;
        end
        default: begin
          // Argument-collecting states; a byte on the expiry cycle wins.
          if (bus.data_valid) begin
            idle_q <= '0;
            case (state_q)
              ROW_SEL: begin
                base_q  <= row_base;
                idx_q   <= '0;
                state_q <= ROW_DATA;
              end
              ROW_DATA: begin
                if (row_full < AW1'(FRAME_BYTES)) begin
                  row_we_q   <= 1'b1;
                  row_addr_q <= row_full[ADDR_W-1:0];
                  row_data_q <= bus.data_rx;
                end
                if (idx_q == IDX_W'(ROW_BYTES - 1)) state_q <= IDLE;
                else                                idx_q   <= idx_q + 1'b1;
              end
              BRIGHT: begin
                bright_q <= BRIGHTNESS_BITS'(bus.data_rx);
                state_q  <= IDLE;
              end
              RGB: begin
                rgb_q   <= bus.data_rx[2:0];
                state_q <= IDLE;
              end
              FILL_COLOR: begin
                fill_q <= fill_shift;
                if (fidx_q == FIDX_W'(BYTES_PER_PIXEL - 1)) state_q <= SWEEP;
                else                                         fidx_q  <= fidx_q + 1'b1;
              end
              default: state_q <= IDLE;
            endcase
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            idle_q    <= '0;
            state_q   <= IDLE;
          end else if (RX_TIMEOUT_TICKS != 0) begin
            idle_q <= idle_q + TO_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.ram_write_enable = row_we_q | sw_busy;
  assign bus.ram_address      = sw_busy ? sw_addr : row_addr_q;
  assign bus.ram_data_out     = sw_busy ? sw_data : row_data_q;
  // row_we_q keeps the RAM clocked for the final row write after IDLE.
  assign bus.ram_clk_enable   = (state_q != IDLE) | row_we_q;

  assign rgb_enable        = rgb_q;
  assign brightness_enable = bright_q;
  assign busy              = sw_busy;
  assign overrun           = overrun_q;
  assign timeout           = timeout_q;

`ifdef CTRL_CMD_STATS_EN
  logic       cmd_done;
  logic       opc_invalid;
  logic [7:0] ncmd_q;
  logic [7:0] ninv_q;

  always_comb begin
    cmd_done    = 1'b0;
    opc_invalid = 1'b0;
    if (state_q == SWEEP) begin
      cmd_done = sw_last;
    end else if (bus.data_valid) begin
      case (state_q)
        IDLE:        opc_invalid = !is_opcode(bus.data_rx);
        ROW_DATA:    cmd_done    = (idx_q == IDX_W'(ROW_BYTES - 1));
        BRIGHT, RGB: cmd_done    = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      ncmd_q <= '0;
      ninv_q <= '0;
    end else begin
      if (cmd_done)                        ncmd_q <= ncmd_q + 1'b1;
      if (opc_invalid && ninv_q != 8'hFF)  ninv_q <= ninv_q + 1'b1;
    end
  end

  assign num_commands_processed = ncmd_q;
  assign num_invalid            = ninv_q;
`endif
endmodule

// File: tb/tb_frame_cmd_writer.sv
module tb_frame_cmd_writer;
  localparam int COLS = 4, ROWS = 2, BPP = 2, BB = 6, TICKS = 20, AW = 4;
  localparam int FRAME = COLS * ROWS * BPP;
  localparam int ROWB  = COLS * BPP;
  localparam logic [7:0] OP_L = 8'h4C, OP_B = 8'h62, OP_R = 8'h72, OP_C = 8'h63, OP_F = 8'h66;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frame_cmd_writer_if #(.ADDR_W(AW)) bus();
  logic [2:0]    rgb_enable;
  logic [BB-1:0] brightness_enable;
  logic          busy, overrun, timeout;
`ifdef CTRL_CMD_STATS_EN
  logic [7:0]    ncmd, ninv;
`endif

  frame_cmd_writer #(
    .COLS(COLS), .ROWS(ROWS), .BYTES_PER_PIXEL(BPP), .BRIGHTNESS_BITS(BB),
    .RX_TIMEOUT_TICKS(TICKS), .ADDR_W(AW)
  ) dut (
    .clk_in(clk), .reset(reset), .bus(bus),
    .rgb_enable(rgb_enable), .brightness_enable(brightness_enable),
    .busy(busy), .overrun(overrun), .timeout(timeout)
`ifdef CTRL_CMD_STATS_EN
    , .num_commands_processed(ncmd), .num_invalid(ninv)
`endif
  );

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_mem [FRAME];
  logic [7:0] got_mem [FRAME];
  logic [7:0] m_args [$];
  logic [7:0] m_color [BPP];
  logic [7:0] m_cmd = 8'h00;   // 0 = no command in progress
  bit         m_sweep = 0;
  int         m_spos = 0;
  logic [BB-1:0] m_bright = '1;
  logic [2:0] m_rgb = 3'b111;
  bit         m_over = 0, m_to = 0, m_we = 0;
  int         m_idle = 0;
  int         m_addr = 0;
  logic [7:0] m_data = 8'h00;
  int         m_ncmd = 0, m_ninv = 0;
  logic [7:0] mb;
  int         mrow;

  task automatic issue(input int a, input logic [7:0] d);
    m_we = 1; m_addr = a; m_data = d; m_mem[a] = d;
  endtask

  task automatic finish_cmd();
    m_cmd = 8'h00; m_args.delete(); m_ncmd = (m_ncmd + 1) % 256;
  endtask

  task automatic start_sweep();
    m_cmd = 8'h00; m_args.delete(); m_sweep = 1; m_spos = 0;
    issue(0, m_color[0]);
  endtask

  always @(posedge clk) begin
    m_we = 0; m_to = 0;
    mb = bus.data_rx;
    if (!reset) begin
      m_cmd = 8'h00; m_args.delete(); m_sweep = 0; m_bright = '1; m_rgb = 3'b111;
      m_over = 0; m_idle = 0; m_ncmd = 0; m_ninv = 0;
    end else if (m_sweep) begin
      if (bus.data_valid) m_over = 1;
      if (m_spos == FRAME - 1) begin
        m_sweep = 0; m_ncmd = (m_ncmd + 1) % 256;
      end else begin
        m_spos++;
        issue(m_spos, m_color[m_spos % BPP]);
      end
    end else if (bus.data_valid) begin
      m_idle = 0;
      if (m_cmd == 8'h00) begin
        if (mb == OP_L || mb == OP_B || mb == OP_R || mb == OP_F) m_cmd = mb;
        else if (mb == OP_C) begin
          for (int k = 0; k < BPP; k++) m_color[k] = 8'h00;
          start_sweep();
        end else if (m_ninv < 255) m_ninv++;
      end else begin
        m_args.push_back(mb);
        if (m_cmd == OP_B) begin
          m_bright = mb[BB-1:0]; finish_cmd();
        end else if (m_cmd == OP_R) begin
          m_rgb = mb[2:0]; finish_cmd();
        end else if (m_cmd == OP_F) begin
          if (m_args.size() == BPP) begin
            for (int k = 0; k < BPP; k++) m_color[k] = m_args[k];
            start_sweep();
          end
        end else if (m_args.size() > 1) begin
          mrow = (int'(m_args[0]) >= ROWS) ? ROWS - 1 : int'(m_args[0]);
          issue(mrow * ROWB + m_args.size() - 2, mb);
          if (m_args.size() == ROWB + 1) finish_cmd();
        end
      end
    end else if (m_cmd != 8'h00) begin
      m_idle++;
      if (m_idle == TICKS) begin
        m_to = 1; m_cmd = 8'h00; m_args.delete(); m_idle = 0;
      end
    end
  end

  // ---------------- per-cycle checker and write capture ----------------
  int wr_addr [$];
  int wr_data [$];
  int tcount = 0;
  bit exp_clk;
  bit ok;

  always @(negedge clk) begin
    if (bus.ram_write_enable === 1'b1) begin
      got_mem[bus.ram_address] = bus.ram_data_out;
      wr_addr.push_back(int'(bus.ram_address));
      wr_data.push_back(int'(bus.ram_data_out));
    end
    if (timeout === 1'b1) tcount++;
    if (chk_en) begin
      exp_clk = (m_cmd != 8'h00) || m_sweep || m_we;
      ok = (busy === m_sweep) && (overrun === m_over) && (timeout === m_to) &&
           (brightness_enable === m_bright) && (rgb_enable === m_rgb) &&
           (bus.ram_write_enable === m_we) && (bus.ram_clk_enable === exp_clk) &&
           (!m_we || (int'(bus.ram_address) == m_addr && bus.ram_data_out === m_data));
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL cycle@%0t: busy %b/%b ovr %b/%b to %b/%b bright %h/%h rgb %h/%h we %b/%b clken %b/%b addr %0d/%0d data %h/%h (got/expected)",
                 $time, busy, m_sweep, overrun, m_over, timeout, m_to, brightness_enable, m_bright,
                 rgb_enable, m_rgb, bus.ram_write_enable, m_we, bus.ram_clk_enable, exp_clk,
                 bus.ram_address, m_addr, bus.ram_data_out, m_data);
      end
`ifdef CTRL_CMD_STATS_EN
      check("num_commands", {24'd0, ncmd}, m_ncmd);
      check("num_invalid", {24'd0, ninv}, m_ninv);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.data_rx = b; bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]    op;
    logic [7:0]    arg;
    logic [BB-1:0] bright;
    logic [2:0]    rgb;
  } vec_t;
  vec_t tbl [6];

  int bcnt;
  int rsel;
  logic [7:0] rb;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.data_rx = 8'h00; bus.data_valid = 1'b0;
    for (int a = 0; a < FRAME; a++) begin m_mem[a] = 8'h00; got_mem[a] = 8'h00; end
    tbl[0] = '{8'h62, 8'h2A, 6'h2A, 3'h7};
    tbl[1] = '{8'h72, 8'h05, 6'h2A, 3'h5};
    tbl[2] = '{8'h62, 8'hFF, 6'h3F, 3'h5};
    tbl[3] = '{8'h72, 8'hFA, 6'h3F, 3'h2};
    tbl[4] = '{8'h5A, 8'h41, 6'h3F, 3'h2};
    tbl[5] = '{8'h62, 8'h00, 6'h00, 3'h2};

    // reset state
    @(negedge clk); chk_en = 1;
    idle(2);
    check("reset rgb", rgb_enable, 3'b111);
    check("reset bright", brightness_enable, 6'h3F);
    check("reset we", bus.ram_write_enable, 0);
    check("reset clken", bus.ram_clk_enable, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    check("reset timeout", timeout, 0);
    reset = 1'b1;
    idle(2);

    // row 1 load
    wr_addr.delete(); wr_data.delete();
    send(OP_L); send(8'h01);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    idle(2);
    check("row1 nwrites", wr_addr.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      check("row1 addr", wr_addr[i], 8 + i);
      check("row1 data", wr_data[i], 8'h10 + i);
    end
    check("row1 idle clken", bus.ram_clk_enable, 0);

    // fill sweep
    wr_addr.delete(); wr_data.delete();
    send(OP_F); send(8'hAB); send(8'hCD);
    bcnt = 0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin bcnt++; @(negedge clk); end
    check("fill busy cycles", bcnt, 16);
    check("fill busy low", busy, 0);
    idle(1);
    check("fill nwrites", wr_addr.size(), 16);
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      check("fill addr", wr_addr[i], i);
      check("fill data", wr_data[i], (i % 2) ? 8'hCD : 8'hAB);
    end

    // clear with byte during sweep
    send(OP_C); idle(2); send(OP_B);
    for (int i = 0; i < 40 && busy === 1'b1; i++) @(negedge clk);
    check("clear busy low", busy, 0);
    idle(2);
    check("clear overrun", overrun, 1);
    check("clear bright kept", brightness_enable, 6'h3F);
    for (int a = 0; a < FRAME; a++) check("clear mem", got_mem[a], 8'h00);

    // row clamp
    wr_addr.delete(); wr_data.delete();
    send(OP_L); send(8'h05);
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    idle(2);
    check("clamp nwrites", wr_addr.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      check("clamp addr", wr_addr[i], 8 + i);
      check("clamp data", wr_data[i], 8'h30 + i);
    end

    // timeout mid-row
    send(OP_L); send(8'h00); send(8'h01); send(8'h02); send(8'h03);
    tcount = 0;
    idle(25);
    check("timeout pulses", tcount, 1);
    check("timeout clken", bus.ram_clk_enable, 0);
    send(OP_B); send(8'h2A); idle(1);
    check("bright after timeout", brightness_enable, 6'h2A);
    check("row0 kept byte", got_mem[2], 8'h03);

    // table of single-argument commands
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].op); send(tbl[i].arg); idle(1);
      check($sformatf("tbl%0d bright", i), brightness_enable, tbl[i].bright);
      check($sformatf("tbl%0d rgb", i), rgb_enable, tbl[i].rgb);
    end

    // reset during a sweep
    send(OP_F); send(8'h11); send(8'h22);
    idle(4);
    reset = 1'b0;
    @(negedge clk);
    check("rst we", bus.ram_write_enable, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);
    check("rst rgb", rgb_enable, 3'b111);
    check("rst bright", brightness_enable, 6'h3F);
    check("rst clken", bus.ram_clk_enable, 0);
    reset = 1'b1;
    idle(20);
    check("rst mem4", got_mem[4], 8'h11);
    check("rst mem5", got_mem[5], 8'h00);

    // randomized stream against the model
    for (int i = 0; i < 300; i++) begin
      rsel = $urandom_range(0, 9);
      case (rsel)
        0: rb = OP_L;
        1: rb = OP_B;
        2: rb = OP_R;
        3: rb = OP_C;
        4: rb = OP_F;
        5: rb = 8'h41;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      send(rb);
      if ($urandom_range(0, 19) == 0) idle(22);
      else idle($urandom_range(0, 2));
    end
    idle(40);
    for (int a = 0; a < FRAME; a++) check($sformatf("final mem[%0d]", a), got_mem[a], m_mem[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
